matrix_elementwise_engine: RTL

// - Multi-mode, multi-lane element-wise matrix processor: add, subtract, scalar-scale, element-wise max.
// - Captures two ROWS x COLS operand matrices on start, then computes LANES elements/cycle in row-major order.
// - Holds the result until the next accepted start.
// - Sits in the matrix datapath between operand staging registers and downstream result consumers.

---
 rtl/matrix_elementwise_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/matrix_elementwise_engine.sv
// Element-wise matrix engine: add / sub / scale / max, LANES elements per cycle.
// Define MATRIX_SATURATE_EN to clamp out-of-range results instead of wrapping.
module matrix_elementwise_engine #(
   parameter int MATRIX_ROWS = 4,
   parameter int MATRIX_COLS = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int LANES       = 2
) (
   input  logic                  clock_signal,
   input  logic                  reset_signal,
   input  logic                  start_operation,
   input  logic [1:0]            operation_mode,
   input  logic [DATA_WIDTH-1:0] scalar_factor,
   input  logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0][DATA_WIDTH-1:0] matrix_a_input,
   input  logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0][DATA_WIDTH-1:0] matrix_b_input,
   output logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0][DATA_WIDTH-1:0] matrix_result_output,
   output logic                  operation_busy,
   output logic                  operation_complete,
   output logic                  result_valid,
   output logic                  overflow_flag
);

   localparam int ROW_W = (MATRIX_ROWS > 1) ? $clog2(MATRIX_ROWS) : 1;
   localparam int COL_W = (MATRIX_COLS > 1) ? $clog2(MATRIX_COLS) : 1;
   localparam int WIDE  = 2 * DATA_WIDTH;

   if ((MATRIX_COLS % LANES) != 0) begin : g_bad_lanes
      $error("MATRIX_COLS must be a multiple of LANES");
   end

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

   state_t state_q, state_d;

   logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0][DATA_WIDTH-1:0] a_q, b_q;
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] scalar_q;
   logic [ROW_W-1:0]      row_q;
   logic [COL_W-1:0]      col_q;
   logic                  last_chunk;

   logic [LANES-1:0][WIDE-1:0]       ea, eb, wide;
   logic [LANES-1:0][DATA_WIDTH-1:0] lane_res;
   logic [LANES-1:0]                 lane_ovf;

   assign last_chunk = (row_q == ROW_W'(MATRIX_ROWS - 1)) &&
                       (col_q == COL_W'(MATRIX_COLS - LANES));

   always_ff @(posedge clock_signal or posedge reset_signal) begin
      if (reset_signal) state_q <= IDLE;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d            = state_q;
      operation_busy     = 1'b0;
      operation_complete = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_operation) state_d = LOAD;
         end
         LOAD: begin
            operation_busy = 1'b1;
            state_d        = COMPUTE;
         end
         COMPUTE: begin
            operation_busy = 1'b1;
            if (last_chunk) state_d = DONE;
         end
         DONE: begin
            operation_complete = 1'b1;
            state_d            = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Double-width arithmetic exposes carry/borrow for range detection
   always_comb begin
      ea       = '0;
      eb       = '0;
      wide     = '0;
      lane_res = '0;
      lane_ovf = '0;
      for (int l = 0; l < LANES; l++) begin
         ea[l] = WIDE'(a_q[row_q][col_q + COL_W'(l)]);
         eb[l] = WIDE'(b_q[row_q][col_q + COL_W'(l)]);
         unique case (mode_q)
            2'b00: begin
               wide[l]     = ea[l] + eb[l];
               lane_ovf[l] = |wide[l][WIDE-1:DATA_WIDTH];
            end
            2'b01: begin
               wide[l]     = ea[l] - eb[l];
               lane_ovf[l] = ea[l] < eb[l];
            end
            2'b10: begin
               wide[l]     = ea[l] * WIDE'(scalar_q);
               lane_ovf[l] = |wide[l][WIDE-1:DATA_WIDTH];
            end
            default: begin
               wide[l] = (ea[l] > eb[l]) ? ea[l] : eb[l];
            end
         endcase
`ifdef MATRIX_SATURATE_EN
         if (lane_ovf[l])
            lane_res[l] = (mode_q == 2'b01) ? '0 : '1;
         else
            lane_res[l] = wide[l][DATA_WIDTH-1:0];
`else
         lane_res[l] = wide[l][DATA_WIDTH-1:0];
`endif
      end
   end

   always_ff @(posedge clock_signal or posedge reset_signal) begin
      if (reset_signal) begin
         a_q                  <= '0;
         b_q                  <= '0;
         mode_q               <= '0;
         scalar_q             <= '0;
         row_q                <= '0;
         col_q                <= '0;
         matrix_result_output <= '0;
         result_valid         <= 1'b0;
         overflow_flag        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_operation) begin
                  a_q           <= matrix_a_input;
                  b_q           <= matrix_b_input;
                  mode_q        <= operation_mode;
                  scalar_q      <= scalar_factor;
                  result_valid  <= 1'b0;
                  overflow_flag <= 1'b0;
               end
            end
            LOAD: begin
               row_q <= '0;
               col_q <= '0;
            end
            COMPUTE: begin
               for (int l = 0; l < LANES; l++)
                  matrix_result_output[row_q][col_q + COL_W'(l)] <= lane_res[l];
               if (|lane_ovf) overflow_flag <= 1'b1;
               if (col_q == COL_W'(MATRIX_COLS - LANES)) begin
                  col_q <= '0;
                  row_q <= row_q + 1'b1;
               end else begin
                  col_q <= col_q + COL_W'(LANES);
               end
               if (last_chunk) result_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
